// File: rtl/led_blink_ctrl.sv
// Multi-channel run-time programmable LED blinker.
// A shared prescaler produces a base tick. Each channel has its own mode, period and
// on-time counted in ticks, and is loaded through a single-cycle config write port.
// Optional brightness control: define LED_PWM_EN to add cfg_bright and a 16-step PWM gate.
module led_blink_ctrl #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned TICK_FREQ = 1000,
    parameter int unsigned NB_CH     = 4,
    parameter int unsigned PER_W     = 16,
    localparam int unsigned CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [PER_W-1:0]   cfg_period,
    input  logic [PER_W-1:0]   cfg_duty,
`ifdef LED_PWM_EN
    input  logic [3:0]         cfg_bright,
`endif
    output logic               tick,
    output logic [NB_CH-1:0]   led,
    output logic [NB_CH-1:0]   ch_active,
    output logic [NB_CH-1:0]   done
);

    localparam int unsigned PRESC  = CLK_FREQ / TICK_FREQ;
    localparam int unsigned PCNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;

    typedef enum logic [1:0] {
        ModeOff     = 2'b00,
        ModeOn      = 2'b01,
        ModeBlink   = 2'b10,
        ModeOneshot = 2'b11
    } mode_e;

    logic [PCNT_W-1:0] pcnt;

    assign tick = (pcnt == PCNT_W'(PRESC - 1));

    // Prescaler: counts 0..PRESC-1 and wraps, tick marks the last count
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase counter at clock rate
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end
`endif

    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        mode_e            mode;
        logic [PER_W-1:0] period;
        logic [PER_W-1:0] duty;
        logic [PER_W-1:0] ccnt;
        logic [PER_W-1:0] peff_m1;
        logic [PER_W:0]   ccnt_inc;
        logic             done_r;
        logic             sel;
        logic             base_on;

        // Out-of-range channel numbers never match, so such writes are dropped
        assign sel      = cfg_we && (cfg_ch == CH_W'(i));
        // Period 0 behaves as period 1
        assign peff_m1  = (period == '0) ? '0 : period - PER_W'(1);
        assign ccnt_inc = {1'b0, ccnt} + (PER_W + 1)'(1);

        // Channel state: a write wins over a simultaneous tick and suppresses done
        always_ff @(posedge CLK) begin
            if (RST) begin
                mode   <= ModeOff;
                period <= '0;
                duty   <= '0;
                ccnt   <= '0;
                done_r <= 1'b0;
            end else begin
                done_r <= 1'b0;
                if (sel) begin
                    mode   <= mode_e'(cfg_mode);
                    period <= cfg_period;
                    duty   <= cfg_duty;
                    ccnt   <= '0;
                end else if (tick) begin
                    unique case (mode)
                        ModeBlink: begin
                            ccnt <= (ccnt == peff_m1) ? '0 : ccnt + PER_W'(1);
                        end
                        ModeOneshot: begin
                            if (ccnt_inc >= {1'b0, duty}) begin
                                mode   <= ModeOff;
                                ccnt   <= '0;
                                done_r <= 1'b1;
                            end else begin
                                ccnt <= ccnt + PER_W'(1);
                            end
                        end
                        default: begin
                            ccnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign base_on = (mode == ModeOn) ||
                         (((mode == ModeBlink) || (mode == ModeOneshot)) && (ccnt < duty));

`ifdef LED_PWM_EN
        logic [3:0] bright;

        // Brightness is loaded alongside the other config fields
        always_ff @(posedge CLK) begin
            if (RST) begin
                bright <= 4'd15;
            end else if (sel) begin
                bright <= cfg_bright;
            end
        end

        assign led[i] = base_on && ((bright == 4'd15) || (pwm_cnt < bright));
`else
        assign led[i] = base_on;
`endif

        assign ch_active[i] = (mode != ModeOff);
        assign done[i]      = done_r;
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl (PRESC=10, 3 channels, 8-bit periods).
// Build with LED_PWM_EN defined to also exercise the brightness gate.
module tb_led_blink_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic [3:0] cfg_bright;
    logic       tick;
    logic [2:0] led;
    logic [2:0] ch_active;
    logic [2:0] done;

    led_blink_ctrl #(
        .CLK_FREQ (100),
        .TICK_FREQ(10),
        .NB_CH    (3),
        .PER_W    (8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .cfg_duty  (cfg_duty),
`ifdef LED_PWM_EN
        .cfg_bright(cfg_bright),
`endif
        .tick      (tick),
        .led       (led),
        .ch_active (ch_active),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] led;
        logic [2:0] act;
        logic [2:0] dn;
        logic       tk;
    } exp_t;

    typedef struct {
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] per;
        logic [7:0] duty;
        logic       el;
        logic       ea;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[6];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    c;
    logic  l1;
    logic  a1;
    string phase = "init";

    // ch0 blink pattern once written at cycle 49 with period 4, duty 2
    function automatic logic b0(input int k);
        return ((k - 50) % 40) < 20;
    endfunction

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                      input logic [7:0] per, input logic [7:0] duty);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_duty   = duty;
    endtask

    // One clock cycle: queue expectation, sample at negedge, advance past posedge
    task automatic step(input bit chk, input logic [2:0] el, input logic [2:0] ea,
                        input logic [2:0] ed);
        exp_t e;
        exp_t g;
        e.led = el;
        e.act = ea;
        e.dn  = ed;
        e.tk  = ((cyc % 10) == 9);
        if (chk) sb.push_back(e);
        @(negedge clk);
        if (chk && sb.size() > 0) begin
            g = sb.pop_front();
            total++;
            if (led !== g.led || ch_active !== g.act || done !== g.dn || tick !== g.tk) begin
                bad++;
                $display("FAIL %s cyc=%0d got led=%b act=%b done=%b tick=%b want led=%b act=%b done=%b tick=%b",
                         phase, cyc, led, ch_active, done, tick, g.led, g.act, g.dn, g.tk);
            end
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        cyc++;
    endtask

    initial begin
        vecs[0] = '{2'd1, 2'b10, 8'd4, 8'd5, 1'b1, 1'b1}; // duty > period: steady on
        vecs[1] = '{2'd1, 2'b10, 8'd0, 8'd1, 1'b1, 1'b1}; // period 0: steady on
        vecs[2] = '{2'd1, 2'b10, 8'd4, 8'd0, 1'b0, 1'b1}; // duty 0: steady off
        vecs[3] = '{2'd1, 2'b01, 8'd0, 8'd0, 1'b1, 1'b1}; // ON
        vecs[4] = '{2'd1, 2'b00, 8'd0, 8'd0, 1'b0, 1'b0}; // OFF
        vecs[5] = '{2'd3, 2'b01, 8'd9, 8'd9, 1'b0, 1'b0}; // bad channel: no change

        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_bright = 4'd15;
        repeat (3) step(0, 3'b0, 3'b0, 3'b0);
        rst = 1'b0;
        cyc = 0;

        phase = "idle";
        repeat (49) step(1, 3'b000, 3'b000, 3'b000);

        // Written in the tick cycle 49: the tick is not applied, ccnt starts at 0
        phase = "blink_ch0";
        wr(2'd0, 2'b10, 8'd4, 8'd2);
        step(1, 3'b000, 3'b000, 3'b000);
        while (cyc < 169) step(1, {2'b00, b0(cyc)}, 3'b001, 3'b000);

        phase = "oneshot_d3";
        wr(2'd2, 2'b11, 8'd0, 8'd3);
        step(1, {2'b00, b0(cyc)}, 3'b001, 3'b000);
        while (cyc < 220)
            step(1, {(cyc <= 199), 1'b0, b0(cyc)}, {(cyc <= 199), 2'b01},
                 {(cyc == 200), 2'b00});

        l1 = 1'b0;
        a1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            phase = $sformatf("table%0d", i);
            wr(vecs[i].ch, vecs[i].mode, vecs[i].per, vecs[i].duty);
            step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
            l1 = vecs[i].el;
            a1 = vecs[i].ea;
            repeat (29) step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
        end

        phase = "oneshot_d0";
        while ((cyc % 10) != 3) step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
        c = cyc;
        wr(2'd2, 2'b11, 8'd0, 8'd0);
        step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
        repeat (15)
            step(1, {1'b0, l1, b0(cyc)}, {(cyc <= c + 6), a1, 1'b1}, {(cyc == c + 7), 2'b00});

        phase = "write_on_tick";
        while ((cyc % 10) != 9) step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
        c = cyc;
        wr(2'd1, 2'b10, 8'd2, 8'd1);
        step(1, {1'b0, l1, b0(cyc)}, {1'b0, a1, 1'b1}, 3'b000);
        repeat (40)
            step(1, {1'b0, (((cyc - c - 1) % 20) < 10), b0(cyc)}, 3'b011, 3'b000);

        // One-cycle reset while ch0 and ch1 blink
        rst = 1'b1;
        step(0, 3'b0, 3'b0, 3'b0);
        rst = 1'b0;
        cyc = 0;
        phase = "post_reset";
        repeat (30) step(1, 3'b000, 3'b000, 3'b000);

`ifdef LED_PWM_EN
        phase = "pwm_b4";
        cfg_bright = 4'd4;
        wr(2'd0, 2'b01, 8'd0, 8'd0);
        step(1, 3'b000, 3'b000, 3'b000);
        repeat (32) step(1, {2'b00, ((cyc % 16) < 4)}, 3'b001, 3'b000);
        phase = "pwm_b15";
        cfg_bright = 4'd15;
        wr(2'd0, 2'b01, 8'd0, 8'd0);
        step(1, {2'b00, ((cyc % 16) < 4)}, 3'b001, 3'b000);
        repeat (20) step(1, 3'b001, 3'b001, 3'b000);
        phase = "pwm_b0";
        cfg_bright = 4'd0;
        wr(2'd0, 2'b01, 8'd0, 8'd0);
        step(1, 3'b001, 3'b001, 3'b000);
        repeat (20) step(1, 3'b000, 3'b001, 3'b000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
- Multi-channel, run-time programmable LED blinker, replacing the fixed per-clock 1 Hz divider counters.
- A shared prescaler divides CLK into a base tick.
- Each channel has its own mode, period and on-time, counted in ticks.
- Sits between the board-level top and the LED pins, configured through a simple write port.

Parameters:
- CLK_FREQ, 50_000_000: CLK frequency in Hz.
- TICK_FREQ, 1000: base tick rate in Hz. PRESC = CLK_FREQ/TICK_FREQ, which must be >= 2.
- NB_CH, 4: number of LED channels, >= 1.
- PER_W, 16: width of the period and duty fields, in ticks.
- Derived: CH_W = max(1, $clog2(NB_CH)).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- cfg_we  in  1  config write strobe, sampled on the CLK rising edge
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT
- cfg_period  in  PER_W  blink period in ticks
- cfg_duty  in  PER_W  on-time in ticks
- tick  out  1  one-cycle pulse at TICK_FREQ
- led  out  NB_CH  LED drive, 1 = lit
- ch_active  out  NB_CH  channel mode != OFF
- done  out  NB_CH  one-cycle pulse when a ONESHOT completes

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high. While RST=1, cfg_we is ignored.
- Reset values: pcnt=0; all channel modes=OFF; period=0; duty=0; ccnt=0; done=0. Hence led=0, ch_active=0, tick=0.
- Reset mid-operation clears everything at that edge. The prescaler restarts and the first tick follows PRESC cycles later.
- Prescaler:
  - pcnt counts 0..PRESC-1 and wraps.
  - tick = (pcnt == PRESC-1).
  - First tick is in cycle PRESC-1 after RST falls (cycle 0 = first cycle with RST=0).
- Channel registers: mode, period, duty, and counter ccnt [PER_W-1:0].
- Effective period Peff = max(period, 1).
- Config write:
  - When cfg_we=1, channel cfg_ch loads mode/period/duty and sets ccnt=0 at that edge. The new state is visible in the next cycle.
  - cfg_ch >= NB_CH: write is ignored and no state changes.
  - A write in a tick cycle wins; that tick is not applied to the written channel.
  - Writes to other channels are unaffected.
- OFF: ccnt held at 0, base_on=0.
- ON: ccnt held at 0, base_on=1.
- BLINK:
  - On each tick, ccnt <= (ccnt == Peff-1) ? 0 : ccnt+1.
  - base_on = (ccnt < duty).
  - duty=0 gives always off; duty >= Peff gives always on.
- ONESHOT:
  - base_on = (ccnt < duty).
  - On each tick: if ccnt+1 >= duty, then mode <= OFF and done[ch] <= 1 for exactly one cycle; otherwise ccnt++.
  - duty=0 completes at the first tick with the LED never lit.
  - period is ignored.
- done is registered: high in the cycle after the completing tick, then 0.
- A write to a channel in the same cycle as its completion suppresses done; the write takes effect.
- led = base_on, gated by the optional feature. led is a function of registered state only; there is no combinational path from cfg_* inputs to led.
- ccnt arithmetic is PER_W bits with no overflow, since ccnt < Peff <= 2^PER_W-1.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - Adds input port cfg_bright [3:0], loaded with the other config fields on a write. Reset value is 15.
  - Adds a free-running 4-bit pwm_cnt at CLK rate, reset to 0.
  - led = base_on && (bright == 15 || pwm_cnt < bright).
  - bright=0 gives LED dark.
- Not defined: cfg_bright and pwm_cnt are absent, and led = base_on.

Test Plan:
- Setup: CLK_FREQ=100, TICK_FREQ=10 (PRESC=10), NB_CH=3, PER_W=8 unless stated.
- Reset, then idle 50 cycles -> led=000, ch_active=000, done=000. tick high in cycles 9, 19, 29, 39, 49 only.
- Write ch0 BLINK, period=4, duty=2, just after a tick -> led[0] high for 20 cycles, low for 20, repeating every 40 cycles. Other LEDs stay 0.
- Write ch2 ONESHOT, duty=3 -> led[2] lit through 3 ticks (about 30 cycles), then 0. done[2]=1 for one cycle after the 3rd tick; ch_active[2] falls with it.
- Boundaries:
  - BLINK duty=5, period=4 -> steady on.
  - BLINK period=0, duty=1 -> steady on.
  - ONESHOT duty=0 -> done at first tick, led never lit.
  - Write with cfg_ch=3 -> no change.
  - Write coinciding with tick -> ccnt=0 next cycle.
- Blink ch1 running, RST high for 1 cycle -> next cycle all outputs 0. First tick at cycle 9 after RST falls. Config is lost.
- With LED_PWM_EN: ch0 ON, bright=4 -> led[0] high exactly 4 of every 16 cycles. bright=15 -> constant 1. bright=0 -> constant 0.
